i2c_slave_byte_rx: RTL and testbench

I2C_SLAVE_BYTE_RX -- requirements
Module: i2c_slave_byte_rx

---
 rtl/i2c_pkg.sv | 18 +
 rtl/i2c_line_filter.sv | 58 +++++
 rtl/i2c_slave_byte_rx.sv | 174 +++++++++++++++++
 tb/tb_i2c_slave_byte_rx.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave byte receiver: FSM state encoding
// and the ACK/NACK levels used on the SDA open-drain enable.
package i2c_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE      = 3'd0,
        BITS      = 3'd1,
        ACK_WAIT  = 3'd2,
        ACK_DRIVE = 3'd3,
        SKIP      = 3'd4
    } state_t;

    localparam logic I2C_ACK  = 1'b1;
    localparam logic I2C_NACK = 1'b0;

endpackage

// File: rtl/i2c_line_filter.sv
// Conditioning for one I2C bus line: a synchronizer chain, a glitch filter
// that only moves after FILTER_LEN consecutive samples disagree with it,
// and single-cycle rise/fall pulses from the filtered level.
// Everything presets to 1 so an idle bus produces no edges out of reset.
module i2c_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic filt,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic [CNT_W-1:0]       cnt;
    logic                   filt_d;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Move the asynchronous pad level into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line_in};
        end
    end

    // Count consecutive disagreeing samples; adopt the new level on the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt   <= 1'b1;
            filt_d <= 1'b1;
            cnt    <= '0;
        end else begin
            filt_d <= filt;
            if (sync_out == filt) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                filt <= sync_out;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = filt & ~filt_d;
    assign fall = ~filt & filt_d;

endmodule

// File: rtl/i2c_slave_byte_rx.sv
// I2C slave receive path: detects START/STOP, shifts in bytes MSB first,
// hands each byte to a consumer and drives its ACK/NACK on the 9th clock.
// Optional clock stretching while waiting for the decision is enabled by
// defining I2C_RX_STRETCH_EN; without it SclOe stays 0 and a missing
// decision becomes NACK.
// ACK handshake: after RxValid the consumer may assert AckValid for one or
// more cycles with Ack alongside; the first cycle with AckValid=1 is the one
// taken, later ones in the same byte are ignored. There is no back-pressure.
module i2c_slave_byte_rx
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       SclIn,
    input  logic       SdaIn,
    output logic       SdaOe,
    output logic       SclOe,
    output logic [7:0] RxByte,
    output logic       RxValid,
    output logic       RxFirst,
    input  logic       AckValid,
    input  logic       Ack,
    output logic       StartDet,
    output logic       StopDet,
    output logic       Busy,
    output state_t     DbgState
);

    logic scl_f, scl_rise, scl_fall;
    logic sda_f, sda_rise, sda_fall;

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl (
        .clk(Clk), .rst(Rst), .line_in(SclIn),
        .filt(scl_f), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda (
        .clk(Clk), .rst(Rst), .line_in(SdaIn),
        .filt(sda_f), .rise(sda_rise), .fall(sda_fall)
    );

    // An SCL edge in the same cycle masks any SDA edge as START/STOP.
    logic scl_edge, start_ev, stop_ev;
    assign scl_edge = scl_rise | scl_fall;
    assign start_ev = sda_fall & scl_f & ~scl_edge;
    assign stop_ev  = sda_rise & scl_f & ~scl_edge;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [6:0] shift;
    logic       first_byte;
    logic       dec_have;
    logic       dec_ack;
    logic       dec_avail;
    logic       dec_now;

    // A decision is available if latched earlier or offered this very cycle.
    assign dec_avail = dec_have | AckValid;
    assign dec_now   = dec_have ? dec_ack : Ack;

`ifdef I2C_RX_STRETCH_EN
    logic scl_oe_q;
    assign SclOe = scl_oe_q;
`else
    assign SclOe = 1'b0;
`endif

    assign DbgState = state;

    // Protocol FSM; START/STOP override whatever the current state is doing.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            shift      <= 7'd0;
            first_byte <= 1'b0;
            dec_have   <= 1'b0;
            dec_ack    <= I2C_NACK;
            SdaOe      <= 1'b0;
            RxByte     <= 8'h00;
            RxValid    <= 1'b0;
            RxFirst    <= 1'b0;
            StartDet   <= 1'b0;
            StopDet    <= 1'b0;
            Busy       <= 1'b0;
`ifdef I2C_RX_STRETCH_EN
            scl_oe_q   <= 1'b0;
`endif
        end else begin
            RxValid  <= 1'b0;
            StartDet <= 1'b0;
            StopDet  <= 1'b0;
            if (stop_ev) begin
                state   <= IDLE;
                SdaOe   <= 1'b0;
                StopDet <= 1'b1;
                Busy    <= 1'b0;
`ifdef I2C_RX_STRETCH_EN
                scl_oe_q <= 1'b0;
`endif
            end else if (start_ev) begin
                state      <= BITS;
                bit_cnt    <= 3'd0;
                first_byte <= 1'b1;
                SdaOe      <= 1'b0;
                StartDet   <= 1'b1;
                Busy       <= 1'b1;
`ifdef I2C_RX_STRETCH_EN
                scl_oe_q   <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: ;
                    BITS: begin
                        if (scl_rise) begin
                            shift   <= {shift[5:0], sda_f};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                RxByte   <= {shift, sda_f};
                                RxValid  <= 1'b1;
                                RxFirst  <= first_byte;
                                dec_have <= 1'b0;
                                dec_ack  <= I2C_NACK;
                                state    <= ACK_WAIT;
                            end
                        end
                    end
                    ACK_WAIT: begin
`ifdef I2C_RX_STRETCH_EN
                        if (scl_oe_q) begin
                            // Holding SCL low: the first decision goes straight onto SDA.
                            if (AckValid) begin
                                SdaOe <= Ack;
                                state <= ACK_DRIVE;
                            end
                        end else if (scl_fall && !dec_avail) begin
                            scl_oe_q <= 1'b1;
                        end else
`endif
                        if (scl_fall) begin
                            SdaOe <= dec_avail ? dec_now : I2C_NACK;
                            state <= ACK_DRIVE;
                        end else if (AckValid && !dec_have) begin
                            dec_have <= 1'b1;
                            dec_ack  <= Ack;
                        end
                    end
                    ACK_DRIVE: begin
`ifdef I2C_RX_STRETCH_EN
                        scl_oe_q <= 1'b0;
`endif
                        // SdaOe still carries the decision for this byte.
                        if (scl_fall) begin
                            SdaOe   <= 1'b0;
                            bit_cnt <= 3'd0;
                            if (SdaOe == I2C_ACK) begin
                                first_byte <= 1'b0;
                                state      <= BITS;
                            end else begin
                                state <= SKIP;
                            end
                        end
                    end
                    SKIP: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_byte_rx.sv
// Bench for i2c_slave_byte_rx: an I2C master driver on an open-drain bus
// model, a consumer answering RxValid, a scoreboard of expected bytes, a
// directed vector table and randomized byte traffic against a
// transaction-level model of the receiver.
module tb_i2c_slave_byte_rx;
  import i2c_pkg::*;

  localparam int Q    = 10;
  localparam int HALF = 20;
`ifdef I2C_RX_STRETCH_EN
  localparam bit STRETCH = 1'b1;
`else
  localparam bit STRETCH = 1'b0;
`endif

  // ---------------- clock / reset / bus ----------------
  logic Clk = 1'b0;
  logic Rst;
  logic scl_m, sda_m, ovr;
  logic scl_bus, sda_bus;
  logic SdaOe, SclOe, RxValid, RxFirst, StartDet, StopDet, Busy;
  logic [7:0] RxByte;
  logic AckValid, Ack;
  state_t DbgState;

  always #5 Clk = ~Clk;

  assign scl_bus = scl_m & ~SclOe;
  assign sda_bus = sda_m & (~SdaOe | ovr);

  i2c_slave_byte_rx #(.SYNC_STAGES(2), .FILTER_LEN(3)) dut (
    .Clk(Clk), .Rst(Rst), .SclIn(scl_bus), .SdaIn(sda_bus),
    .SdaOe(SdaOe), .SclOe(SclOe), .RxByte(RxByte), .RxValid(RxValid),
    .RxFirst(RxFirst), .AckValid(AckValid), .Ack(Ack),
    .StartDet(StartDet), .StopDet(StopDet), .Busy(Busy), .DbgState(DbgState)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;
  int start_cnt = 0;
  int stop_cnt = 0;

  always @(negedge Clk) begin
    if (!Rst) begin
      if (StartDet) start_cnt++;
      if (StopDet) stop_cnt++;
      if (RxValid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rxvalid actual=%0h expected=none", {RxFirst, RxByte});
        end else begin
          mon_e = exp_q.pop_front();
          chk("rx_first_byte", 32'({RxFirst, RxByte}), 32'(mon_e));
        end
      end
    end
  end

  // ---------------- consumer ----------------
  bit cur_give = 1'b1;
  bit cur_ack = 1'b1;
  int cur_delay = 2;
  bit chk_stretch = 1'b0;

  initial begin
    AckValid = 1'b0;
    Ack = 1'b0;
    forever begin
      @(negedge Clk);
      if (RxValid && cur_give && !Rst) begin
        repeat (cur_delay) @(negedge Clk);
`ifdef I2C_RX_STRETCH_EN
        if (chk_stretch) chk1("stretch_scl_held", SclOe, 1'b1);
`endif
        AckValid = 1'b1;
        Ack = cur_ack;
        @(negedge Clk);
        AckValid = 1'b0;
        Ack = 1'b0;
`ifdef I2C_RX_STRETCH_EN
        if (chk_stretch) begin
          chk1("stretch_sdaoe_set", SdaOe, 1'b1);
          chk1("stretch_scl_still", SclOe, 1'b1);
          @(negedge Clk);
          chk1("stretch_scl_drop", SclOe, 1'b0);
        end
`endif
      end
    end
  end

  // ---------------- master driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic scl_high();
    int t;
    t = 0;
    scl_m = 1'b1;
    while (scl_bus !== 1'b1 && t < 2000) begin
      @(negedge Clk);
      t++;
    end
    if (t >= 2000) begin
      checks++;
      failures++;
      $display("FAIL scl_release_timeout actual=low expected=high");
    end
  endtask

  task automatic send_start();
    sda_m = 1'b0; cyc(HALF);
    scl_m = 1'b0; cyc(Q);
  endtask

  task automatic send_rstart();
    sda_m = 1'b1; cyc(Q);
    scl_high(); cyc(Q);
    sda_m = 1'b0; cyc(Q);
    scl_m = 1'b0; cyc(Q);
  endtask

  task automatic send_stop();
    sda_m = 1'b0; cyc(Q);
    scl_high(); cyc(Q);
    sda_m = 1'b1; cyc(HALF);
  endtask

  task automatic send_bits(input logic [7:0] d, input int n, output int hits);
    hits = 0;
    for (int i = 0; i < n; i++) begin
      sda_m = d[7-i]; cyc(Q);
      scl_high(); cyc(HALF/2);
      if (SdaOe) hits++;
      cyc(HALF/2);
      scl_m = 1'b0; cyc(Q);
    end
  endtask

  task automatic ack_bit(output logic oe_mid, output state_t st_mid);
    sda_m = 1'b1; cyc(Q);
    scl_high(); cyc(HALF/2);
    oe_mid = SdaOe;
    st_mid = DbgState;
    cyc(HALF/2);
    scl_m = 1'b0; cyc(Q);
  endtask

  task automatic run_byte(input logic [7:0] d, input bit give, input bit ack,
                          input bit ev, input bit ef, input bit ea, input string tag);
    int hits;
    logic oe_mid;
    state_t st_mid;
    if (STRETCH && !give) begin
      give = 1'b1;
      ack = 1'b0;
    end
    cur_give = give;
    cur_ack = ack;
    if (ev) exp_q.push_back({ef, d});
    send_bits(d, 8, hits);
    chk({tag, "_data_oe"}, hits, 0);
    ack_bit(oe_mid, st_mid);
    chk1({tag, "_ack"}, oe_mid, ea);
    chk({tag, "_ack_state"}, 32'(st_mid), 32'(ev ? ACK_DRIVE : SKIP));
    chk1({tag, "_oe_released"}, SdaOe, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef enum int {K_START, K_RSTART, K_BYTE, K_PART, K_STOP} kind_t;
  typedef struct {
    kind_t kind;
    logic [7:0] data;
    int nbits;
    bit give;
    bit ack;
    bit exp_valid;
    bit exp_first;
    bit exp_ack;
    state_t exp_state;
    int exp_starts;
    int exp_stops;
    bit exp_busy;
  } vec_t;

  vec_t tbl[10];

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main test ----------------
  initial begin
    int s0, p0, hits;
    logic oe_mid;
    state_t st_mid;
    bit m_first, m_skip, give, ack, ev, acked;
    logic [7:0] d;
    int r;
    bit seen;

    tbl[0] = '{K_START,  8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, BITS, 1, 0, 1'b1};
    tbl[1] = '{K_BYTE,   8'hA4, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, BITS, 0, 0, 1'b1};
    tbl[2] = '{K_BYTE,   8'h5C, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, SKIP, 0, 0, 1'b1};
    tbl[3] = '{K_BYTE,   8'hFF, 8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, SKIP, 0, 0, 1'b1};
    tbl[4] = '{K_RSTART, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, BITS, 1, 0, 1'b1};
    tbl[5] = '{K_PART,   8'hA0, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, BITS, 0, 0, 1'b1};
    tbl[6] = '{K_RSTART, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, BITS, 1, 0, 1'b1};
    tbl[7] = '{K_BYTE,   8'h3B, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, BITS, 0, 0, 1'b1};
    tbl[8] = '{K_BYTE,   8'h7E, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, SKIP, 0, 0, 1'b1};
    tbl[9] = '{K_STOP,   8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, 0, 1, 1'b0};

    // reset values
    Rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; ovr = 1'b0;
    cyc(5);
    chk("rst_state", 32'(DbgState), 32'(IDLE));
    chk1("rst_sdaoe", SdaOe, 1'b0);
    chk1("rst_scloe", SclOe, 1'b0);
    chk1("rst_rxvalid", RxValid, 1'b0);
    chk1("rst_rxfirst", RxFirst, 1'b0);
    chk1("rst_startdet", StartDet, 1'b0);
    chk1("rst_stopdet", StopDet, 1'b0);
    chk1("rst_busy", Busy, 1'b0);
    chk("rst_rxbyte", 32'(RxByte), 32'h00);
    Rst = 1'b0;
    cyc(10);

    // directed vector table
    for (int i = 0; i < 10; i++) begin
      s0 = start_cnt;
      p0 = stop_cnt;
      case (tbl[i].kind)
        K_START:  send_start();
        K_RSTART: send_rstart();
        K_STOP:   send_stop();
        K_PART: begin
          send_bits(tbl[i].data, tbl[i].nbits, hits);
          chk($sformatf("tbl%0d_part_oe", i), hits, 0);
        end
        default: run_byte(tbl[i].data, tbl[i].give, tbl[i].ack, tbl[i].exp_valid,
                          tbl[i].exp_first, tbl[i].exp_ack, $sformatf("tbl%0d", i));
      endcase
      chk($sformatf("tbl%0d_state", i), 32'(DbgState), 32'(tbl[i].exp_state));
      chk1($sformatf("tbl%0d_busy", i), Busy, tbl[i].exp_busy);
      chk($sformatf("tbl%0d_starts", i), start_cnt - s0, tbl[i].exp_starts);
      chk($sformatf("tbl%0d_stops", i), stop_cnt - p0, tbl[i].exp_stops);
    end

    // 1-cycle SDA glitch on an idle bus must not look like START
    s0 = start_cnt;
    sda_m = 1'b0; cyc(1); sda_m = 1'b1; cyc(20);
    chk("glitch_idle_starts", start_cnt - s0, 0);
    chk("glitch_idle_state", 32'(DbgState), 32'(IDLE));

    // 1-cycle SDA glitch high right after START must not look like STOP
    s0 = start_cnt;
    p0 = stop_cnt;
    sda_m = 1'b0; cyc(10);
    sda_m = 1'b1; cyc(1);
    sda_m = 1'b0; cyc(10);
    scl_m = 1'b0; cyc(Q);
    chk("glitch_start_starts", start_cnt - s0, 1);
    chk("glitch_start_stops", stop_cnt - p0, 0);
    chk("glitch_start_state", 32'(DbgState), 32'(BITS));
    run_byte(8'h96, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "glitch_byte");
    send_stop();

    // STOP while the ACK is being driven
    send_start();
    cur_give = 1'b1; cur_ack = 1'b1;
    exp_q.push_back({1'b1, 8'h11});
    send_bits(8'h11, 8, hits);
    p0 = stop_cnt;
    sda_m = 1'b0; cyc(Q);
    scl_high(); cyc(HALF/2);
    chk1("stopack_oe_before", SdaOe, 1'b1);
    chk("stopack_state_before", 32'(DbgState), 32'(ACK_DRIVE));
    ovr = 1'b1;
    sda_m = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 60; t++) begin
      @(negedge Clk);
      if (StopDet) begin
        seen = 1'b1;
        break;
      end
    end
    chk1("stopack_stopdet", seen, 1'b1);
    chk1("stopack_oe_after", SdaOe, 1'b0);
    chk1("stopack_busy", Busy, 1'b0);
    chk("stopack_state", 32'(DbgState), 32'(IDLE));
    cyc(5);
    ovr = 1'b0;
    chk("stopack_stops", stop_cnt - p0, 1);
    cyc(10);

    // reset in the middle of driving ACK releases the bus on the first edge
    send_start();
    cur_give = 1'b1; cur_ack = 1'b1;
    exp_q.push_back({1'b1, 8'hE7});
    send_bits(8'hE7, 8, hits);
    sda_m = 1'b1; cyc(Q);
    scl_high(); cyc(HALF/2);
    chk1("midrst_oe_before", SdaOe, 1'b1);
    Rst = 1'b1;
    cyc(1);
    chk1("midrst_sdaoe", SdaOe, 1'b0);
    chk1("midrst_scloe", SclOe, 1'b0);
    chk1("midrst_busy", Busy, 1'b0);
    chk("midrst_state", 32'(DbgState), 32'(IDLE));
    chk("midrst_rxbyte", 32'(RxByte), 32'h00);
    scl_m = 1'b1; sda_m = 1'b1;
    cyc(5);
    s0 = start_cnt;
    Rst = 1'b0;
    cyc(20);
    chk("midrst_no_start", start_cnt - s0, 0);
    chk("midrst_idle", 32'(DbgState), 32'(IDLE));

`ifdef I2C_RX_STRETCH_EN
    // late decision: SCL is held low until AckValid arrives
    send_start();
    cur_give = 1'b1; cur_ack = 1'b1; cur_delay = 50; chk_stretch = 1'b1;
    exp_q.push_back({1'b1, 8'hC3});
    send_bits(8'hC3, 8, hits);
    ack_bit(oe_mid, st_mid);
    chk1("stretch_ack", oe_mid, 1'b1);
    chk("stretch_ack_state", 32'(st_mid), 32'(ACK_DRIVE));
    chk_stretch = 1'b0; cur_delay = 2;
    send_stop();
    cyc(10);
`endif

    // randomized traffic against a transaction-level model
    send_start();
    m_first = 1'b1;
    m_skip = 1'b0;
    for (int n = 0; n < 24; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        send_rstart();
        m_first = 1'b1;
        m_skip = 1'b0;
      end else if (r == 1) begin
        send_stop();
        cyc(10);
        send_start();
        m_first = 1'b1;
        m_skip = 1'b0;
      end else begin
        d = 8'($urandom);
        give = STRETCH ? 1'b1 : ($urandom_range(0, 3) != 0);
        ack = 1'($urandom_range(0, 1));
        acked = give & ack;
        ev = !m_skip;
        run_byte(d, give, ack, ev, m_first, ev & acked, $sformatf("rnd%0d", n));
        if (ev) begin
          if (acked) m_first = 1'b0;
          else m_skip = 1'b1;
        end
      end
      chk($sformatf("rnd%0d_state", n), 32'(DbgState), 32'(m_skip ? SKIP : BITS));
    end
    send_stop();
    cyc(20);
    chk("final_idle", 32'(DbgState), 32'(IDLE));
    chk("exp_q_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
